// File: rtl/pipe_chain.sv
// Multi-stage instruction pipeline register chain with per-stage stall/flush,
// bubble insertion behind stalls, and youngest-first register forwarding lookup.
module pipe_chain #(
   parameter int DATA_W = 32,
   parameter int STAGES = 4,
   parameter int REG_AW = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_W-1:0]              InD,
   input  logic [REG_AW-1:0]              RdD,
   input  logic                           RegWriteD,
   input  logic                           ValidD,
   input  logic [STAGES-1:0]              Stall,
   input  logic [STAGES-1:0]              Flush,
   input  logic [REG_AW-1:0]              Rs1X,
   input  logic [REG_AW-1:0]              Rs2X,
   output logic [STAGES*DATA_W-1:0]       DataS,
   output logic [STAGES*REG_AW-1:0]       RdS,
   output logic [STAGES-1:0]              RegWriteS,
   output logic [STAGES-1:0]              ValidS,
   output logic [$clog2(STAGES+1)-1:0]    ForwardA,
   output logic [$clog2(STAGES+1)-1:0]    ForwardB,
   output logic [$clog2(STAGES+1)-1:0]    Count,
   output logic                           Empty
);

   localparam int CW = $clog2(STAGES+1);

   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];
   logic [REG_AW-1:0] rd_q   [STAGES];
   logic [REG_AW-1:0] rd_d   [STAGES];
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] rw_q, rw_d;
   logic [STAGES-1:0] hold_e;
   logic [STAGES-1:0] rw_eff;

   // A stall at stage k freezes every older-input stage below it as well.
   always_comb begin
      logic acc;
      acc = 1'b0;
      for (int k = STAGES-1; k >= 0; k--) begin
         acc       = acc | Stall[k];
         hold_e[k] = acc;
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         data_d[k] = data_q[k];
         rd_d[k]   = rd_q[k];
      end
      valid_d = valid_q;
      rw_d    = rw_q;

      if (Flush[0]) begin
         data_d[0]  = '0;
         rd_d[0]    = '0;
         valid_d[0] = 1'b0;
         rw_d[0]    = 1'b0;
      end else if (!hold_e[0]) begin
         data_d[0]  = InD;
         rd_d[0]    = RdD;
         valid_d[0] = ValidD;
         rw_d[0]    = RegWriteD;
      end

      for (int k = 1; k < STAGES; k++) begin
         if (Flush[k] || (!hold_e[k] && hold_e[k-1])) begin
            data_d[k]  = '0;
            rd_d[k]    = '0;
            valid_d[k] = 1'b0;
            rw_d[k]    = 1'b0;
         end else if (!hold_e[k]) begin
            data_d[k]  = data_q[k-1];
            rd_d[k]    = rd_q[k-1];
            valid_d[k] = valid_q[k-1];
            rw_d[k]    = rw_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            rd_q[k]   <= '0;
         end
         valid_q <= '0;
         rw_q    <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
            rd_q[k]   <= rd_d[k];
         end
         valid_q <= valid_d;
         rw_q    <= rw_d;
      end
   end

   assign rw_eff = valid_q & rw_q;

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         DataS[k*DATA_W +: DATA_W] = data_q[k];
         RdS[k*REG_AW +: REG_AW]   = rd_q[k];
      end
      ValidS    = valid_q;
      RegWriteS = rw_eff;
   end

   // Scan oldest to youngest so the youngest matching stage overrides.
   always_comb begin
      ForwardA = '0;
      ForwardB = '0;
      for (int k = STAGES-1; k >= 0; k--) begin
         if (rw_eff[k] && (rd_q[k] == Rs1X) && (Rs1X != '0))
            ForwardA = CW'(k+1);
         if (rw_eff[k] && (rd_q[k] == Rs2X) && (Rs2X != '0))
            ForwardB = CW'(k+1);
      end
   end

   always_comb begin
      Count = '0;
      for (int k = 0; k < STAGES; k++)
         Count = Count + CW'(valid_q[k]);
   end

   assign Empty = (Count == '0);

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: directed scenarios then randomized traffic, all checked
// against a stage-array reference model.
module tb_pipe_chain;

   localparam int DW = 32;
   localparam int ST = 4;
   localparam int AW = 5;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [DW-1:0]     InD;
   logic [AW-1:0]     RdD;
   logic              RegWriteD;
   logic              ValidD;
   logic [ST-1:0]     Stall;
   logic [ST-1:0]     Flush;
   logic [AW-1:0]     Rs1X;
   logic [AW-1:0]     Rs2X;
   logic [ST*DW-1:0]  DataS;
   logic [ST*AW-1:0]  RdS;
   logic [ST-1:0]     RegWriteS;
   logic [ST-1:0]     ValidS;
   logic [CW-1:0]     ForwardA;
   logic [CW-1:0]     ForwardB;
   logic [CW-1:0]     Count;
   logic              Empty;

   pipe_chain #(.DATA_W(DW), .STAGES(ST), .REG_AW(AW)) dut (
      .clk(clk), .reset(reset), .InD(InD), .RdD(RdD), .RegWriteD(RegWriteD),
      .ValidD(ValidD), .Stall(Stall), .Flush(Flush), .Rs1X(Rs1X), .Rs2X(Rs2X),
      .DataS(DataS), .RdS(RdS), .RegWriteS(RegWriteS), .ValidS(ValidS),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .Count(Count), .Empty(Empty)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] m_d  [ST];
   logic [AW-1:0] m_rd [ST];
   logic          m_v  [ST];
   logic          m_rw [ST];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < ST; k++) begin
         m_d[k] = '0; m_rd[k] = '0; m_v[k] = 1'b0; m_rw[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic          h [ST];
      logic          acc;
      logic [DW-1:0] o_d  [ST];
      logic [AW-1:0] o_rd [ST];
      logic          o_v  [ST];
      logic          o_rw [ST];
      acc = 1'b0;
      for (int k = ST-1; k >= 0; k--) begin
         acc  = acc | Stall[k];
         h[k] = acc;
      end
      for (int k = 0; k < ST; k++) begin
         o_d[k] = m_d[k]; o_rd[k] = m_rd[k]; o_v[k] = m_v[k]; o_rw[k] = m_rw[k];
      end
      for (int k = 0; k < ST; k++) begin
         if (Flush[k]) begin
            m_d[k] = '0; m_rd[k] = '0; m_v[k] = 1'b0; m_rw[k] = 1'b0;
         end else if (h[k]) begin
            // hold: keep old contents
         end else if (k == 0) begin
            m_d[0] = InD; m_rd[0] = RdD; m_v[0] = ValidD; m_rw[0] = RegWriteD;
         end else if (h[k-1]) begin
            m_d[k] = '0; m_rd[k] = '0; m_v[k] = 1'b0; m_rw[k] = 1'b0;
         end else begin
            m_d[k] = o_d[k-1]; m_rd[k] = o_rd[k-1]; m_v[k] = o_v[k-1]; m_rw[k] = o_rw[k-1];
         end
      end
   endtask

   function automatic int exp_fwd(input logic [AW-1:0] rs);
      for (int k = 0; k < ST; k++)
         if (m_v[k] && m_rw[k] && m_rd[k] == rs && rs != 0) return k + 1;
      return 0;
   endfunction

   task automatic check_model(input string ctx);
      logic [ST*DW-1:0] e_d;
      logic [ST*AW-1:0] e_rd;
      logic [ST-1:0]    e_v, e_rw;
      int               cnt;
      cnt = 0;
      for (int k = 0; k < ST; k++) begin
         e_d[k*DW +: DW]  = m_d[k];
         e_rd[k*AW +: AW] = m_rd[k];
         e_v[k]           = m_v[k];
         e_rw[k]          = m_v[k] & m_rw[k];
         cnt              = cnt + (m_v[k] ? 1 : 0);
      end
      chk({ctx, ".DataS"}, 128'(DataS), 128'(e_d));
      chk({ctx, ".RdS"}, 128'(RdS), 128'(e_rd));
      chk({ctx, ".ValidS"}, 128'(ValidS), 128'(e_v));
      chk({ctx, ".RegWriteS"}, 128'(RegWriteS), 128'(e_rw));
      chk({ctx, ".ForwardA"}, 128'(ForwardA), 128'(exp_fwd(Rs1X)));
      chk({ctx, ".ForwardB"}, 128'(ForwardB), 128'(exp_fwd(Rs2X)));
      chk({ctx, ".Count"}, 128'(Count), 128'(cnt));
      chk({ctx, ".Empty"}, 128'(Empty), 128'(cnt == 0));
   endtask

   task automatic tick(input string ctx);
      @(posedge clk);
      if (!reset) model_edge();
      #1;
      check_model(ctx);
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] rd, input string ctx);
      InD = d; RdD = rd; RegWriteD = 1'b1; ValidD = 1'b1;
      tick(ctx);
   endtask

   initial begin
      reset = 1'b1; InD = '0; RdD = '0; RegWriteD = 1'b0; ValidD = 1'b0;
      Stall = '0; Flush = '0; Rs1X = '0; Rs2X = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      chk("reset_empty", 128'(Empty), 128'(1));

      // Fill an unstalled pipe
      reset = 1'b0;
      push(32'h11, 5'd1, "fill1");
      push(32'h22, 5'd2, "fill2");
      push(32'h33, 5'd3, "fill3");
      push(32'h44, 5'd4, "fill4");
      chk("fill_data", 128'(DataS), {32'h0, 32'h11, 32'h22, 32'h33, 32'h44});
      chk("fill_count", 128'(Count), 128'(4));

      // Mid-pipe stall leaves a bubble behind it
      InD = 32'h55; RdD = 5'd6; Stall = 4'b0010;
      tick("stall1");
      chk("stall1_valid", 128'(ValidS), 128'(4'b1011));
      chk("stall1_data", 128'(DataS), {32'h0, 32'h22, 32'h0, 32'h33, 32'h44});
      Stall = '0;
      push(32'h55, 5'd6, "refill1");
      push(32'h66, 5'd6, "refill2");

      // Flush wins against an effective hold
      Flush = 4'b0100; Stall = 4'b1000; InD = 32'h99;
      tick("flush_hold");
      chk("flush_hold_valid", 128'(ValidS), 128'(4'b1011));
      chk("flush_hold_data", 128'(DataS), {32'h0, 32'h33, 32'h0, 32'h55, 32'h66});
      Flush = '0; Stall = '0;

      // Forwarding priority
      push(32'hA1, 5'd5, "fwd1");
      push(32'hA2, 5'd7, "fwd2");
      push(32'hA3, 5'd5, "fwd3");
      Rs1X = 5'd5; Rs2X = 5'd7; #1;
      chk("fwdA_young", 128'(ForwardA), 128'(1));
      chk("fwdB_stage1", 128'(ForwardB), 128'(2));
      Rs1X = 5'd0; #1;
      chk("fwdA_r0", 128'(ForwardA), 128'(0));
      Rs1X = 5'd5; Flush = 4'b0001; Stall = 4'b1000;
      tick("fwd_flush0");
      chk("fwdA_older", 128'(ForwardA), 128'(3));
      chk("pre_reset_count", 128'(Count), 128'(3));
      Flush = '0; Stall = '0;

      // Asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_model("async_reset");
      chk("async_reset_empty", 128'(Empty), 128'(1));
      ValidD = 1'b1; InD = 32'hBB;
      tick("reset_held");
      reset = 1'b0; InD = 32'h77; RdD = 5'd2;
      tick("first_load");
      chk("first_load_v0", 128'(ValidS[0]), 128'(1));
      chk("first_load_d0", 128'(DataS[DW-1:0]), 128'(32'h77));

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         InD       = $urandom;
         RdD       = AW'($urandom_range(0, 7));
         RegWriteD = 1'($urandom);
         ValidD    = ($urandom_range(0, 3) != 0);
         Stall     = ($urandom_range(0, 3) == 0) ? ST'(1 << $urandom_range(0, ST-1)) : '0;
         Flush     = ($urandom_range(0, 4) == 0) ? ST'($urandom) : '0;
         Rs1X      = AW'($urandom_range(0, 7));
         Rs2X      = AW'($urandom_range(0, 7));
         reset     = ($urandom_range(0, 63) == 0);
         if (reset) model_reset();
         tick("rand");
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
